// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared UART encodings (parity, baud), divisor helper and the
//            transmitter state type; reused by the matching receiver.
// Revision : 1.0
// ============================================================================
package uart_pkg;

    localparam logic [1:0] PAR_NONE   = 2'b00;
    localparam logic [1:0] PAR_ODD    = 2'b01;
    localparam logic [1:0] PAR_EVEN   = 2'b10;

    localparam logic [1:0] BAUD_2400  = 2'b00;
    localparam logic [1:0] BAUD_4800  = 2'b01;
    localparam logic [1:0] BAUD_9600  = 2'b10;
    localparam logic [1:0] BAUD_19200 = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    // Bit period in system clocks, truncated.
    function automatic logic [15:0] baud_divisor(
        input logic [1:0]  baud_code,
        input int unsigned clk_freq_hz
    );
        int unsigned w_rate;
        int unsigned w_div;
        case (baud_code)
            BAUD_2400:  w_rate = 32'd2400;
            BAUD_4800:  w_rate = 32'd4800;
            BAUD_9600:  w_rate = 32'd9600;
            default:    w_rate = 32'd19200;
        endcase
        w_div = clk_freq_hz / w_rate;
        return w_div[15:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_gen
// Purpose  : Bit-period timer; loads the divisor on restart and strobes at
//            the last clock of every bit (plus a one-clock-early strobe).
// Revision : 1.0
// ============================================================================
module uart_baud_gen (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_restart,
    input  logic        i_enable,
    input  logic [15:0] i_divisor,
    output logic        o_bit_end,
    output logic        o_near_end
);

    logic [15:0] r_count;
    logic [15:0] r_div;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= 16'd0;
            r_div   <= 16'd0;
        end else if (i_restart) begin
            r_count <= 16'd0;
            r_div   <= i_divisor;
        end else if (i_enable) begin
            if (o_bit_end) begin
                r_count <= 16'd0;
            end else begin
                r_count <= r_count + 16'd1;
            end
        end
    end

    // near_end lets the owner register a pulse that lands on the bit's last clock.
    assign o_bit_end  = i_enable && (r_count == r_div - 16'd1);
    assign o_near_end = i_enable && (r_count == r_div - 16'd2);

endmodule
`default_nettype wire

// File: rtl/uart_tx_unit.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_unit
// Purpose  : UART transmitter: start, 8 data bits LSB first, optional parity,
//            stop. Define UART_TX_STOP2_EN for two stop bits.
// Revision : 1.0
// ============================================================================
module uart_tx_unit
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50000000,
    parameter int unsigned DATA_W      = 8
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       send,
    input  logic [7:0] data_in,
    input  logic [1:0] parity_type,
    input  logic [1:0] baud_rate,
    output logic       data_tx,
    output logic       ready,
    output logic       done
);

    tx_state_t         r_state;
    logic [DATA_W-1:0] r_shift;
    logic [2:0]        r_bit_idx;
    logic              r_par_en;
    logic              r_par_bit;
    logic              r_tx;
    logic              r_ready;
    logic              r_done;

    logic              w_accept;
    logic              w_busy;
    logic              w_bit_end;
    logic              w_near_end;
    logic              w_stop_last;
    logic [15:0]       w_divisor;

    assign w_accept  = (r_state == IDLE) && send;
    assign w_busy    = (r_state != IDLE);
    assign w_divisor = baud_divisor(baud_rate, CLK_FREQ_HZ);

    uart_baud_gen u_baud_gen (
        .i_clk      (clock),
        .i_rst_n    (reset_n),
        .i_restart  (w_accept),
        .i_enable   (w_busy),
        .i_divisor  (w_divisor),
        .o_bit_end  (w_bit_end),
        .o_near_end (w_near_end)
    );

`ifdef UART_TX_STOP2_EN
    logic r_stop_second;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_stop_second <= 1'b0;
        end else if (w_accept) begin
            r_stop_second <= 1'b0;
        end else if ((r_state == STOP) && w_bit_end) begin
            r_stop_second <= ~r_stop_second;
        end
    end

    assign w_stop_last = r_stop_second;
`else
    assign w_stop_last = 1'b1;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_idx <= 3'd0;
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
            r_tx      <= 1'b1;
            r_ready   <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (send) begin
                        r_shift   <= data_in;
                        r_bit_idx <= 3'd0;
                        r_par_en  <= (parity_type == PAR_ODD) || (parity_type == PAR_EVEN);
                        r_par_bit <= (parity_type == PAR_ODD) ? ~^data_in : ^data_in;
                        r_state   <= START;
                        r_tx      <= 1'b0;
                        r_ready   <= 1'b0;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_state <= DATA;
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        if (r_bit_idx == 3'(DATA_W - 1)) begin
                            if (r_par_en) begin
                                r_state <= PARITY;
                                r_tx    <= r_par_bit;
                            end else begin
                                r_state <= STOP;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_tx      <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                        end
                    end
                end
                PARITY: begin
                    if (w_bit_end) begin
                        r_state <= STOP;
                        r_tx    <= 1'b1;
                    end
                end
                STOP: begin
                    // done is registered one clock ahead so it coincides with the last stop clock
                    if (w_near_end && w_stop_last) begin
                        r_done <= 1'b1;
                    end
                    if (w_bit_end && w_stop_last) begin
                        r_state <= IDLE;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign data_tx = r_tx;
    assign ready   = r_ready;
    assign done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_unit.sv
`default_nettype none
// Bench for uart_tx_unit: per-cycle comparison against a queue of expected line
// levels built from the frame rules, plus directed literal checks.
module tb_uart_tx_unit;

    localparam int TB_CLK = 240000;
`ifdef UART_TX_STOP2_EN
    localparam int NSTOP = 2;
`else
    localparam int NSTOP = 1;
`endif

    logic       clock       = 1'b0;
    logic       reset_n     = 1'b1;
    logic       send        = 1'b0;
    logic [7:0] data_in     = 8'h00;
    logic [1:0] parity_type = 2'b00;
    logic [1:0] baud_rate   = 2'b00;
    logic       data_tx;
    logic       ready;
    logic       done;

    int   total = 0;
    int   bad   = 0;
    int   n;
    logic exp_q[$];
    logic was_idle;
    logic cap[12];
    logic [7:0] rx_byte;

    uart_tx_unit #(.CLK_FREQ_HZ(TB_CLK), .DATA_W(8)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .send        (send),
        .data_in     (data_in),
        .parity_type (parity_type),
        .baud_rate   (baud_rate),
        .data_tx     (data_tx),
        .ready       (ready),
        .done        (done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: dut=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_div(input logic [1:0] code, input int clk_hz);
        int rate;
        rate = 2400 << code;
        return clk_hz / rate;
    endfunction

    function automatic logic model_par(input logic [7:0] d, input logic [1:0] pt);
        int ones;
        ones = $countones(d);
        if (pt == 2'b01) return (ones % 2 == 0);
        return (ones % 2 == 1);
    endfunction

    function automatic void push_frame(input logic [7:0] d, input logic [1:0] pt, input logic [1:0] br);
        int   div;
        logic bits[$];
        div = model_div(br, TB_CLK);
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (pt == 2'b01 || pt == 2'b10) bits.push_back(model_par(d, pt));
        for (int s = 0; s < NSTOP; s++) bits.push_back(1'b1);
        foreach (bits[k]) for (int c = 0; c < div; c++) exp_q.push_back(bits[k]);
    endfunction

    // Model: one queue entry per clock of the frame in progress.
    always @(posedge clock) begin
        if (reset_n === 1'b1) begin
            was_idle = (exp_q.size() == 0);
            if (!was_idle) void'(exp_q.pop_front());
            if (was_idle && send === 1'b1) push_frame(data_in, parity_type, baud_rate);
        end
    end

    always @(negedge reset_n) exp_q.delete();

    always @(negedge clock) begin
        if (reset_n === 1'b1) begin
            chk("line",  {31'd0, data_tx}, {31'd0, (exp_q.size() != 0) ? exp_q[0] : 1'b1});
            chk("ready", {31'd0, ready},   {31'd0, exp_q.size() == 0});
            chk("done",  {31'd0, done},    {31'd0, exp_q.size() == 1});
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (!(ready === 1'b1 && exp_q.size() == 0) && k < budget) begin
            tick();
            k++;
        end
        total++;
        if (k >= budget) begin
            bad++;
            $display("FAIL idle_timeout: busy after %0d cycles, expected idle", k);
        end
    endtask

    task automatic send_one(input logic [7:0] d, input logic [1:0] pt, input logic [1:0] br);
        wait_idle(3000);
        send = 1'b1; data_in = d; parity_type = pt; baud_rate = br;
        tick();
        send = 1'b0; data_in = ~d; parity_type = ~pt; baud_rate = ~br;
    endtask

    task automatic measure_done(input string name, input int exp_cyc);
        int k;
        k = 0;
        while (done !== 1'b1 && k < 4000) begin
            tick();
            k++;
        end
        chk(name, k, exp_cyc);
        tick();
        chk({name, "_ready_after"}, {31'd0, ready}, 32'd1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        chk("pin_div9600_tb",   model_div(2'b10, TB_CLK), 25);
        chk("pin_div9600_50M",  model_div(2'b10, 50000000), 5208);
        chk("pin_div2400_50M",  model_div(2'b00, 50000000), 20833);
        chk("pin_div19200_50M", model_div(2'b11, 50000000), 2604);
        chk("pin_par55_odd",    {31'd0, model_par(8'h55, 2'b01)}, 1);
        chk("pin_parA5_even",   {31'd0, model_par(8'hA5, 2'b10)}, 0);

        #3 reset_n = 1'b0;
        #1;
        chk("reset_line",  {31'd0, data_tx}, 1);
        chk("reset_ready", {31'd0, ready},   1);
        chk("reset_done",  {31'd0, done},    0);
        repeat (3) @(posedge clock);
        #2 reset_n = 1'b1;

        send_one(8'h55, 2'b01, 2'b10);
        measure_done("len_55_odd_9600", (10 + NSTOP) * 25 - 1);

        send_one(8'hA5, 2'b10, 2'b11);
        measure_done("len_A5_even_19200", (10 + NSTOP) * 12 - 1);

        send_one(8'h00, 2'b00, 2'b00);
        measure_done("len_00_none_2400", (9 + NSTOP) * 100 - 1);

        // Loopback-style decode at mid-bit
        send_one(8'h3C, 2'b01, 2'b10);
        for (int c = 0; c < (10 + NSTOP) * 25; c++) begin
            if (c % 25 == 12) cap[c / 25] = data_tx;
            tick();
        end
        for (int b = 0; b < 8; b++) rx_byte[b] = cap[b + 1];
        chk("loop_start",  {31'd0, cap[0]},  0);
        chk("loop_data",   {24'd0, rx_byte}, 32'h3C);
        chk("loop_parity", {31'd0, cap[9]},  1);
        chk("loop_stop",   {31'd0, cap[10]}, 1);

        // Reset during data bit 1 (a 0 bit) of 0x55
        send_one(8'h55, 2'b01, 2'b10);
        repeat (55) tick();
        #1 reset_n = 1'b0;
        #1;
        chk("midrst_line",  {31'd0, data_tx}, 1);
        chk("midrst_ready", {31'd0, ready},   1);
        chk("midrst_done",  {31'd0, done},    0);
        tick();
        chk("midrst_hold_done", {31'd0, done}, 0);
        reset_n = 1'b1;

        // Back-to-back with send held and inputs changed mid-frame
        wait_idle(3000);
        send = 1'b1; data_in = 8'h12; parity_type = 2'b01; baud_rate = 2'b11;
        tick();
        data_in = 8'h34; parity_type = 2'b10;
        n = 0;
        while (done !== 1'b1 && n < 4000) begin
            tick();
            n++;
        end
        chk("b2b_first_len", n, (10 + NSTOP) * 12 - 1);
        tick();
        chk("b2b_gap_ready", {31'd0, ready},   1);
        chk("b2b_gap_line",  {31'd0, data_tx}, 1);
        tick();
        chk("b2b_second_ready", {31'd0, ready},   0);
        chk("b2b_second_start", {31'd0, data_tx}, 0);
        send = 1'b0;

        // Random frames with noise on the inputs while busy
        for (int it = 0; it < 20; it++) begin
            repeat ($urandom_range(0, 3)) tick();
            send_one(8'($urandom), 2'($urandom), 2'($urandom_range(0, 3)));
            n = 0;
            while (ready !== 1'b1 && n < 3000) begin
                send        = ($urandom_range(0, 7) == 0);
                data_in     = 8'($urandom);
                parity_type = 2'($urandom);
                baud_rate   = 2'($urandom);
                tick();
                n++;
            end
            send = 1'b0;
        end

        wait_idle(3000);
        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
